// File: rtl/keccak_pkg.sv
// rtl/keccak_pkg.sv - shared Keccak-f[1600] widths, FSM states, rho offsets and round constants
package keccak_pkg;

    localparam int STATE_W = 1600;
    localparam int LANE_W  = 64;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    // Compressed round constants: bit j maps to lane bit (2**j - 1).
    localparam logic [6:0] RC [24] = '{
        7'h01, 7'h1A, 7'h5E, 7'h70, 7'h1F, 7'h21, 7'h79, 7'h55,
        7'h0E, 7'h0C, 7'h35, 7'h26, 7'h3F, 7'h4F, 7'h5D, 7'h53,
        7'h52, 7'h48, 7'h16, 7'h66, 7'h79, 7'h58, 7'h21, 7'h74
    };

    // Rho rotation amounts, indexed by lane x + 5*y.
    localparam int RHO [25] = '{
         0,  1, 62, 28, 27,
        36, 44,  6, 55, 20,
         3, 10, 43, 25, 39,
        41, 45, 15, 21,  8,
        18,  2, 61, 56, 14
    };

    function automatic logic [LANE_W-1:0] rotl64(input logic [LANE_W-1:0] v, input int n);
        if (n == 0) return v;
        return (v << n) | (v >> (LANE_W - n));
    endfunction

    function automatic logic [LANE_W-1:0] rc_expand(input logic [6:0] c);
        logic [LANE_W-1:0] r;
        r = '0;
        for (int j = 0; j < 7; j++) r[(1 << j) - 1] = c[j];
        return r;
    endfunction

    // Indices past the table only arise for rounds that are never committed.
    function automatic logic [6:0] rc_at(input logic [5:0] idx);
        if (idx < 6'd24) return RC[idx[4:0]];
        return 7'h00;
    endfunction

endpackage

// File: rtl/keccak_round_engine_round.sv
// rtl/keccak_round_engine_round.sv - one combinational Keccak-f[1600] round (theta, rho, pi, chi, iota)
module keccak_round_engine_round
    import keccak_pkg::*;
(
    input  logic [STATE_W-1:0] s_in,
    input  logic [6:0]         rc_c,
    output logic [STATE_W-1:0] s_out
);

    logic [LANE_W-1:0] a [25];
    logic [LANE_W-1:0] t [25];
    logic [LANE_W-1:0] b [25];
    logic [LANE_W-1:0] e [25];
    logic [LANE_W-1:0] c [5];
    logic [LANE_W-1:0] d [5];

    // Full round on the unpacked 5x5 lane array, lane (x,y) at index x + 5*y.
    always_comb begin
        a     = '{default: '0};
        t     = '{default: '0};
        b     = '{default: '0};
        e     = '{default: '0};
        c     = '{default: '0};
        d     = '{default: '0};
        s_out = '0;
        for (int i = 0; i < 25; i++) a[i] = s_in[i*LANE_W +: LANE_W];
        for (int x = 0; x < 5; x++) c[x] = a[x] ^ a[x+5] ^ a[x+10] ^ a[x+15] ^ a[x+20];
        for (int x = 0; x < 5; x++) d[x] = c[(x+4)%5] ^ rotl64(c[(x+1)%5], 1);
        for (int i = 0; i < 25; i++) t[i] = a[i] ^ d[i%5];
        for (int x = 0; x < 5; x++) begin
            for (int y = 0; y < 5; y++) begin
                b[y + 5*((2*x + 3*y) % 5)] = rotl64(t[x + 5*y], RHO[x + 5*y]);
            end
        end
        for (int x = 0; x < 5; x++) begin
            for (int y = 0; y < 5; y++) begin
                e[x + 5*y] = b[x + 5*y] ^ (~b[(x+1)%5 + 5*y] & b[(x+2)%5 + 5*y]);
            end
        end
        e[0] = e[0] ^ rc_expand(rc_c);
        for (int i = 0; i < 25; i++) s_out[i*LANE_W +: LANE_W] = e[i];
    end

endmodule

// File: rtl/keccak_round_engine.sv
// rtl/keccak_round_engine.sv - iterative Keccak-f[1600] engine, UNROLL rounds per clock; optional abort via KECCAK_ENGINE_ABORT_EN
module keccak_round_engine
    import keccak_pkg::*;
#(
    parameter int UNROLL = 1,
    parameter int NR     = 24
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [STATE_W-1:0] data_in,
    output logic               out_valid,
    input  logic               out_ready,
`ifdef KECCAK_ENGINE_ABORT_EN
    input  logic               abort,
`endif
    output logic [STATE_W-1:0] data_out
);

    if ((NR % UNROLL) != 0 || NR > 24 || NR < 1) begin : g_bad_cfg
        $error("keccak_round_engine: NR must be 1..24 and a multiple of UNROLL");
    end

    state_e             state_q, state_d;
    logic [4:0]         rnd_q, rnd_d;
    logic [STATE_W-1:0] st_q, st_d;

    logic [STATE_W-1:0] chain  [UNROLL+1];
    logic [6:0]         rc_sel [UNROLL];

    assign chain[0] = st_q;

    for (genvar g = 0; g < UNROLL; g++) begin : g_round
        assign rc_sel[g] = rc_at(6'(rnd_q) + 6'(g));
        keccak_round_engine_round u_round (
            .s_in  (chain[g]),
            .rc_c  (rc_sel[g]),
            .s_out (chain[g+1])
        );
    end

    // Next-state, round counter and state-register update; abort overrides at the end.
    always_comb begin
        state_d  = state_q;
        rnd_d    = rnd_q;
        st_d     = st_q;
        in_ready = (state_q == ST_IDLE) || (state_q == ST_DONE && out_ready);
        case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    st_d    = data_in;
                    rnd_d   = '0;
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                st_d  = chain[UNROLL];
                rnd_d = rnd_q + 5'(UNROLL);
                if ((6'(rnd_q) + 6'(UNROLL)) == 6'(NR)) state_d = ST_DONE;
            end
            ST_DONE: begin
                if (out_ready) begin
                    if (in_valid) begin
                        st_d    = data_in;
                        rnd_d   = '0;
                        state_d = ST_RUN;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
`ifdef KECCAK_ENGINE_ABORT_EN
        if (abort && state_q != ST_IDLE) begin
            state_d = ST_IDLE;
            rnd_d   = rnd_q;
            st_d    = st_q;
        end
`endif
    end

    // Registers with synchronous reset taking priority over everything.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            rnd_q   <= '0;
            st_q    <= '0;
        end else begin
            state_q <= state_d;
            rnd_q   <= rnd_d;
            st_q    <= st_d;
        end
    end

    assign out_valid = (state_q == ST_DONE);
    assign data_out  = st_q;

endmodule

// File: tb/tb_keccak_round_engine.sv
// tb/tb_keccak_round_engine.sv - randomized bench for keccak_round_engine with UNROLL 1, 2 and 4 against a FIPS 202 model
module tb_keccak_round_engine;

    localparam int UN [3] = '{1, 2, 4};

    logic          clk = 1'b0;
    logic          reset;
    logic          iv   [3];
    logic          ir   [3];
    logic          ov   [3];
    logic          ordy [3];
    logic [1599:0] di   [3];
    logic [1599:0] dout [3];
`ifdef KECCAK_ENGINE_ABORT_EN
    logic          ab   [3];
`endif

    int            n_tests = 0;
    int            n_fail  = 0;
    logic [1599:0] zero_out;

    always #5 clk = ~clk;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        keccak_round_engine #(.UNROLL(UN[g]), .NR(24)) u_dut (
            .clk       (clk),
            .reset     (reset),
            .in_valid  (iv[g]),
            .in_ready  (ir[g]),
            .data_in   (di[g]),
            .out_valid (ov[g]),
            .out_ready (ordy[g]),
`ifdef KECCAK_ENGINE_ABORT_EN
            .abort     (ab[g]),
`endif
            .data_out  (dout[g])
        );
    end

    // Reference model straight from FIPS 202: 5x5 lanes, LFSR round constants, walked rho offsets.
    function automatic logic [63:0] ref_rotl(input logic [63:0] v, input int n);
        int m;
        m = n % 64;
        if (m == 0) return v;
        return (v << m) | (v >> (64 - m));
    endfunction

    function automatic logic ref_rc_bit(input int t);
        logic [8:0] r;
        if (t % 255 == 0) return 1'b1;
        r = 9'h001;
        for (int i = 1; i <= t % 255; i++) begin
            r    = r << 1;
            r[0] = r[0] ^ r[8];
            r[4] = r[4] ^ r[8];
            r[5] = r[5] ^ r[8];
            r[6] = r[6] ^ r[8];
            r[8] = 1'b0;
        end
        return r[0];
    endfunction

    function automatic logic [1599:0] keccak_ref(input logic [1599:0] s, input int nr);
        logic [63:0] a [5][5];
        logic [63:0] b [5][5];
        logic [63:0] c [5];
        logic [63:0] d [5];
        logic [63:0] rc;
        logic [1599:0] o;
        int x, y, nx, ny;
        for (int i = 0; i < 5; i++)
            for (int j = 0; j < 5; j++) a[i][j] = s[64*(i+5*j) +: 64];
        for (int ir_ = 0; ir_ < nr; ir_++) begin
            for (int i = 0; i < 5; i++) c[i] = a[i][0] ^ a[i][1] ^ a[i][2] ^ a[i][3] ^ a[i][4];
            for (int i = 0; i < 5; i++) d[i] = c[(i+4)%5] ^ ref_rotl(c[(i+1)%5], 1);
            for (int i = 0; i < 5; i++)
                for (int j = 0; j < 5; j++) a[i][j] = a[i][j] ^ d[i];
            x = 1; y = 0;
            for (int t = 0; t < 24; t++) begin
                a[x][y] = ref_rotl(a[x][y], ((t+1)*(t+2)/2) % 64);
                nx = y; ny = (2*x + 3*y) % 5; x = nx; y = ny;
            end
            for (int i = 0; i < 5; i++)
                for (int j = 0; j < 5; j++) b[j][(2*i + 3*j) % 5] = a[i][j];
            for (int i = 0; i < 5; i++)
                for (int j = 0; j < 5; j++) a[i][j] = b[i][j] ^ (~b[(i+1)%5][j] & b[(i+2)%5][j]);
            rc = '0;
            for (int j = 0; j < 7; j++) rc[(1 << j) - 1] = ref_rc_bit(j + 7*ir_);
            a[0][0] = a[0][0] ^ rc;
        end
        o = '0;
        for (int i = 0; i < 5; i++)
            for (int j = 0; j < 5; j++) o[64*(i+5*j) +: 64] = a[i][j];
        return o;
    endfunction

    function automatic logic [1599:0] rand_state();
        logic [1599:0] s;
        for (int i = 0; i < 50; i++) s[32*i +: 32] = $urandom;
        return s;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_wait(input int k, input logic [1599:0] d, output int lat);
        iv[k] = 1'b1;
        di[k] = d;
        tick();
        iv[k] = 1'b0;
        lat = -1;
        for (int c = 1; c <= 200; c++) begin
            tick();
            if (ov[k]) begin
                lat = c;
                break;
            end
        end
    endtask

    task automatic drain(input int k);
        ordy[k] = 1'b1;
        tick();
        ordy[k] = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        for (int k = 0; k < 3; k++) begin
            n_tests++;
            if (ov[k] !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid[%0d]: got %b expected 0", k, ov[k]); end
            n_tests++;
            if (ir[k] !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready[%0d]: got %b expected 1", k, ir[k]); end
            n_tests++;
            if (dout[k] !== '0) begin n_fail++; $display("FAIL reset_data_out[%0d]: got %h expected 0", k, dout[k][127:0]); end
        end
    endtask

    task automatic test_zero_u1();
        int lat;
        logic [1599:0] exp_s;
        exp_s = keccak_ref('0, 24);
        send_wait(0, '0, lat);
        n_tests++;
        if (lat !== 24) begin n_fail++; $display("FAIL zero_u1_latency: got %0d expected 24", lat); end
        n_tests++;
        if (dout[0][63:0] !== 64'hF1258F7940E1DDE7) begin
            n_fail++; $display("FAIL zero_u1_lane0: got %h expected f1258f7940e1dde7", dout[0][63:0]);
        end
        n_tests++;
        if (dout[0] !== exp_s) begin n_fail++; $display("FAIL zero_u1_state: got %h expected %h", dout[0][127:0], exp_s[127:0]); end
        zero_out = dout[0];
        drain(0);
    endtask

    task automatic test_zero_u4();
        int lat;
        send_wait(2, '0, lat);
        n_tests++;
        if (lat !== 6) begin n_fail++; $display("FAIL zero_u4_latency: got %0d expected 6", lat); end
        n_tests++;
        if (dout[2] !== zero_out) begin n_fail++; $display("FAIL zero_u4_state: got %h expected %h", dout[2][127:0], zero_out[127:0]); end
        drain(2);
    endtask

    task automatic test_random();
        int lat;
        logic [1599:0] d, exp_s;
        for (int k = 0; k < 3; k++) begin
            for (int r = 0; r < 2; r++) begin
                d = rand_state();
                exp_s = keccak_ref(d, 24);
                send_wait(k, d, lat);
                n_tests++;
                if (lat !== 24 / UN[k]) begin n_fail++; $display("FAIL random_latency[%0d]: got %0d expected %0d", k, lat, 24 / UN[k]); end
                n_tests++;
                if (dout[k] !== exp_s) begin n_fail++; $display("FAIL random_state[%0d]: got %h expected %h", k, dout[k][127:0], exp_s[127:0]); end
                drain(k);
            end
        end
    endtask

    task automatic test_stall();
        int lat;
        logic [1599:0] hold;
        send_wait(0, rand_state(), lat);
        hold  = dout[0];
        iv[0] = 1'b1;
        di[0] = rand_state();
        for (int c = 0; c < 10; c++) begin
            n_tests++;
            if (ir[0] !== 1'b0) begin n_fail++; $display("FAIL stall_in_ready cycle %0d: got %b expected 0", c, ir[0]); end
            tick();
            n_tests++;
            if (dout[0] !== hold || ov[0] !== 1'b1) begin
                n_fail++; $display("FAIL stall_hold cycle %0d: got valid %b data %h expected valid 1 data %h", c, ov[0], dout[0][127:0], hold[127:0]);
            end
        end
        iv[0]   = 1'b0;
        drain(0);
        n_tests++;
        if (ov[0] !== 1'b0 || ir[0] !== 1'b1) begin
            n_fail++; $display("FAIL stall_release: got valid %b ready %b expected valid 0 ready 1", ov[0], ir[0]);
        end
        n_tests++;
        if (dout[0] !== hold) begin n_fail++; $display("FAIL stall_nothing_accepted: got %h expected %h", dout[0][127:0], hold[127:0]); end
    endtask

    task automatic test_back_to_back();
        int lat, gap;
        logic [1599:0] a, b;
        a = rand_state();
        b = rand_state();
        send_wait(1, a, lat);
        n_tests++;
        if (dout[1] !== keccak_ref(a, 24)) begin n_fail++; $display("FAIL b2b_first_state: got %h", dout[1][127:0]); end
        ordy[1] = 1'b1;
        iv[1]   = 1'b1;
        di[1]   = b;
        #1;
        n_tests++;
        if (ir[1] !== 1'b1) begin n_fail++; $display("FAIL b2b_in_ready_done: got %b expected 1", ir[1]); end
        tick();
        ordy[1] = 1'b0;
        iv[1]   = 1'b0;
        gap = -1;
        for (int c = 1; c <= 200; c++) begin
            tick();
            if (ov[1]) begin
                gap = c + 1;
                break;
            end
        end
        n_tests++;
        if (gap !== 13) begin n_fail++; $display("FAIL b2b_spacing: got %0d expected 13", gap); end
        n_tests++;
        if (dout[1] !== keccak_ref(b, 24)) begin n_fail++; $display("FAIL b2b_second_state: got %h", dout[1][127:0]); end
        drain(1);
    endtask

    task automatic test_reset_mid_run();
        int lat;
        bit seen;
        logic [1599:0] cdat;
        iv[0] = 1'b1;
        di[0] = rand_state();
        tick();
        iv[0] = 1'b0;
        repeat (10) tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        n_tests++;
        if (ov[0] !== 1'b0 || ir[0] !== 1'b1 || dout[0] !== '0) begin
            n_fail++; $display("FAIL midrun_reset: got valid %b ready %b data %h expected 0 1 0", ov[0], ir[0], dout[0][127:0]);
        end
        iv[0] = 1'b1;
        di[0] = rand_state();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        iv[0] = 1'b0;
        n_tests++;
        if (ir[0] !== 1'b1 || dout[0] !== '0) begin
            n_fail++; $display("FAIL reset_vs_handshake: got ready %b data %h expected 1 0", ir[0], dout[0][127:0]);
        end
        seen = 1'b0;
        repeat (30) begin
            tick();
            if (ov[0]) seen = 1'b1;
        end
        n_tests++;
        if (seen !== 1'b0) begin n_fail++; $display("FAIL reset_vs_handshake_valid: got %b expected 0", seen); end
        cdat = rand_state();
        send_wait(0, cdat, lat);
        n_tests++;
        if (lat !== 24 || dout[0] !== keccak_ref(cdat, 24)) begin
            n_fail++; $display("FAIL post_reset_run: got latency %0d data %h", lat, dout[0][127:0]);
        end
        drain(0);
    endtask

`ifdef KECCAK_ENGINE_ABORT_EN
    task automatic test_abort();
        int lat;
        bit seen;
        logic [1599:0] a, hold;
        a = rand_state();
        iv[0] = 1'b1;
        di[0] = a;
        tick();
        iv[0] = 1'b0;
        repeat (5) tick();
        ab[0] = 1'b1;
        tick();
        ab[0] = 1'b0;
        n_tests++;
        if (ir[0] !== 1'b1 || ov[0] !== 1'b0) begin n_fail++; $display("FAIL abort_idle: got ready %b valid %b expected 1 0", ir[0], ov[0]); end
        n_tests++;
        if (dout[0] !== keccak_ref(a, 5)) begin n_fail++; $display("FAIL abort_state_kept: got %h", dout[0][127:0]); end
        seen = 1'b0;
        repeat (40) begin
            tick();
            if (ov[0]) seen = 1'b1;
        end
        n_tests++;
        if (seen !== 1'b0) begin n_fail++; $display("FAIL abort_no_valid: got %b expected 0", seen); end
        send_wait(0, rand_state(), lat);
        hold    = dout[0];
        ab[0]   = 1'b1;
        iv[0]   = 1'b1;
        ordy[0] = 1'b1;
        di[0]   = rand_state();
        tick();
        ab[0]   = 1'b0;
        iv[0]   = 1'b0;
        ordy[0] = 1'b0;
        n_tests++;
        if (ov[0] !== 1'b0 || ir[0] !== 1'b1 || dout[0] !== hold) begin
            n_fail++; $display("FAIL abort_beats_accept: got valid %b ready %b data %h", ov[0], ir[0], dout[0][127:0]);
        end
    endtask
`endif

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1;
        for (int k = 0; k < 3; k++) begin
            iv[k]   = 1'b0;
            ordy[k] = 1'b0;
            di[k]   = '0;
`ifdef KECCAK_ENGINE_ABORT_EN
            ab[k]   = 1'b0;
`endif
        end
        zero_out = '0;
        test_reset();
        test_zero_u1();
        test_zero_u4();
        test_random();
        test_stall();
        test_back_to_back();
        test_reset_mid_run();
`ifdef KECCAK_ENGINE_ABORT_EN
        test_abort();
`endif
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
